// File: rtl/elevator_pkg.sv
// Shared floor/state types and floor-index helpers for the elevator call front end.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 8;
    localparam int unsigned FLOOR_W    = 4;

    typedef logic [FLOOR_W-1:0]    floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        TRAVEL,
        DWELL
    } sched_state_t;

    // Button/pending bit i corresponds to floor i+1.
    function automatic floor_t idx_to_floor(input int unsigned idx);
        return FLOOR_W'(idx + 1);
    endfunction

    function automatic floor_mask_t floor_to_mask(input floor_t f);
        floor_mask_t m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (f == idx_to_floor(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/floor_request_scheduler_scan_select.sv
// SCAN target picker: nearest pending floor in the current direction, else reverse.
module scan_select
    import elevator_pkg::*;
(
    input  floor_mask_t i_pending,
    input  floor_t      i_current_floor,
    input  logic        i_dir_up,
    output logic        o_found,
    output floor_t      o_target,
    output logic        o_new_dir,
    output logic        o_at_floor
);

    logic   w_found_up;
    logic   w_found_dn;
    floor_t w_up;
    floor_t w_dn;

    // Lowest pending floor above the car and highest pending floor below it.
    always_comb begin
        w_found_up = 1'b0;
        w_found_dn = 1'b0;
        w_up       = '0;
        w_dn       = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (i_pending[i] && (idx_to_floor(i) > i_current_floor) && !w_found_up) begin
                w_up       = idx_to_floor(i);
                w_found_up = 1'b1;
            end
            if (i_pending[i] && (idx_to_floor(i) < i_current_floor)) begin
                w_dn       = idx_to_floor(i);
                w_found_dn = 1'b1;
            end
        end
    end

    always_comb begin
        o_found    = 1'b0;
        o_target   = '0;
        o_new_dir  = i_dir_up;
        o_at_floor = |(i_pending & floor_to_mask(i_current_floor));
        if (i_dir_up) begin
            if (w_found_up) begin
                o_found  = 1'b1;
                o_target = w_up;
            end else if (w_found_dn) begin
                o_found   = 1'b1;
                o_target  = w_dn;
                o_new_dir = 1'b0;
            end
        end else begin
            if (w_found_dn) begin
                o_found  = 1'b1;
                o_target = w_dn;
            end else if (w_found_up) begin
                o_found   = 1'b1;
                o_target  = w_up;
                o_new_dir = 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_request_scheduler.sv
// Call-button front end: latches presses, orders them SCAN-style and drives the
// car controller's requested_floor, retiring each request on arrival.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_buttons,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    sched_state_t r_state;
    floor_mask_t  r_btn_prev;
    logic         r_armed;
    floor_mask_t  r_pending;
    floor_t       r_requested_floor;
    logic         r_dir_up;
    logic         r_busy;
    logic [CNT_W-1:0] r_dwell_cnt;

    floor_mask_t w_rise;
    floor_mask_t w_clear;
    logic        w_arrive;
    logic        w_retarget;
    logic        w_found;
    floor_t      w_target;
    logic        w_new_dir;
    logic        w_at_floor;

    scan_select u_scan_select (
        .i_pending       (r_pending),
        .i_current_floor (current_floor),
        .i_dir_up        (r_dir_up),
        .o_found         (w_found),
        .o_target        (w_target),
        .o_new_dir       (w_new_dir),
        .o_at_floor      (w_at_floor)
    );

    // History is meaningless on the first cycle out of reset, so buttons already
    // held then must wait for a fresh rising edge.
    assign w_rise   = r_armed ? (call_buttons & ~r_btn_prev) : '0;
    assign w_arrive = (r_state == TRAVEL) && (current_floor == r_requested_floor) && car_idle;

    // Only a pending floor strictly between the car and its target, ahead of it, retargets.
    assign w_retarget = (r_state == TRAVEL) && !w_arrive && w_found && (w_new_dir == r_dir_up) &&
                        (r_dir_up ? (w_target < r_requested_floor)
                                  : (w_target > r_requested_floor));

    // Retired floor; also masks a same-cycle press for that floor.
    always_comb begin
        w_clear = '0;
        if ((r_state == DISPATCH) && w_at_floor) begin
            w_clear = floor_to_mask(current_floor);
        end else if (w_arrive) begin
            w_clear = floor_to_mask(r_requested_floor);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state           <= IDLE;
            r_btn_prev        <= '0;
            r_armed           <= 1'b0;
            r_pending         <= '0;
            r_requested_floor <= '0;
            r_dir_up          <= 1'b1;
            r_busy            <= 1'b0;
            r_dwell_cnt       <= '0;
        end else begin
            r_btn_prev <= call_buttons;
            r_armed    <= 1'b1;
            r_pending  <= (r_pending | w_rise) & ~w_clear;
            case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_state <= DISPATCH;
                        r_busy  <= 1'b1;
                    end
                end
                DISPATCH: begin
                    if (w_at_floor) begin
                        r_state     <= DWELL;
                        r_dwell_cnt <= '0;
                    end else if (w_found) begin
                        r_requested_floor <= w_target;
                        r_dir_up          <= w_new_dir;
                        r_state           <= TRAVEL;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                TRAVEL: begin
                    if (w_arrive) begin
                        r_state     <= DWELL;
                        r_dwell_cnt <= '0;
                    end else if (w_retarget) begin
                        r_requested_floor <= w_target;
                    end
                end
                DWELL: begin
                    if (r_dwell_cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                        r_dwell_cnt <= '0;
                        if (|r_pending) begin
                            r_state <= DISPATCH;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign requested_floor = r_requested_floor;
    assign pending         = r_pending;
    assign dir_up          = r_dir_up;
    assign busy            = r_busy;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scoreboard bench: a floor-level SCAN reference model and a simple car plant
// predict every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_floor_request_scheduler;
    import elevator_pkg::*;

    localparam int unsigned DWELL = 4;
    localparam int          NF    = 8;

    localparam int MD_IDLE     = 0;
    localparam int MD_DISPATCH = 1;
    localparam int MD_TRAVEL   = 2;
    localparam int MD_DWELL    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] call_buttons;
    logic [3:0] current_floor;
    logic       car_idle;
    logic [3:0] requested_floor;
    logic [7:0] pending;
    logic       dir_up;
    logic       busy;

    always #5 clk = ~clk;

    floor_request_scheduler #(.DWELL_CYCLES(DWELL)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .call_buttons    (call_buttons),
        .current_floor   (current_floor),
        .car_idle        (car_idle),
        .requested_floor (requested_floor),
        .pending         (pending),
        .dir_up          (dir_up),
        .busy            (busy)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [7:0] pend;
        logic       dir;
        logic       bsy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, floors indexed by floor number.
    int       m_mode;
    bit       m_pend [1:8];
    bit [7:0] m_prev;
    bit       m_armed;
    int       m_req;
    bit       m_dir;
    int       m_cnt;

    // Car plant state.
    int car_pos;
    bit car_idle_v;
    int settle;
    int move_cnt;
    bit rnd_mode;

    int req_log[$];
    bit log_en = 1'b0;
    int last_req = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.req = 4'(m_req);
        for (int f = 1; f <= NF; f++) e.pend[f-1] = m_pend[f];
        e.dir = m_dir;
        e.bsy = (m_mode != MD_IDLE);
        return e;
    endfunction

    function automatic bit any_pending();
        for (int f = 1; f <= NF; f++) if (m_pend[f]) return 1'b1;
        return 1'b0;
    endfunction

    // Lowest pending floor strictly inside (lo, hi); 0 when none.
    function automatic int pick_above(input int lo, input int hi);
        for (int f = 1; f <= NF; f++) if (m_pend[f] && f > lo && f < hi) return f;
        return 0;
    endfunction

    // Highest pending floor strictly inside (lo, hi); 0 when none.
    function automatic int pick_below(input int hi, input int lo);
        for (int f = NF; f >= 1; f--) if (m_pend[f] && f < hi && f > lo) return f;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode  = MD_IDLE;
        for (int f = 1; f <= NF; f++) m_pend[f] = 1'b0;
        m_prev  = '0;
        m_armed = 1'b0;
        m_req   = 0;
        m_dir   = 1'b1;
        m_cnt   = 0;
    endtask

    task automatic model_step(input bit [7:0] btn, input int cur, input bit idle);
        bit rise [1:8];
        int clr;
        int up;
        int dn;
        bit any;
        clr = 0;
        any = any_pending();
        for (int f = 1; f <= NF; f++) rise[f] = m_armed && btn[f-1] && !m_prev[f-1];
        case (m_mode)
            MD_IDLE: if (any) m_mode = MD_DISPATCH;
            MD_DISPATCH: begin
                if (cur >= 1 && cur <= NF && m_pend[cur]) begin
                    clr = cur; m_mode = MD_DWELL; m_cnt = 0;
                end else begin
                    up = pick_above(cur, 99);
                    dn = pick_below(cur, 0);
                    if (m_dir) begin
                        if (up != 0) begin m_req = up; m_mode = MD_TRAVEL; end
                        else if (dn != 0) begin m_req = dn; m_dir = 1'b0; m_mode = MD_TRAVEL; end
                        else m_mode = MD_IDLE;
                    end else begin
                        if (dn != 0) begin m_req = dn; m_mode = MD_TRAVEL; end
                        else if (up != 0) begin m_req = up; m_dir = 1'b1; m_mode = MD_TRAVEL; end
                        else m_mode = MD_IDLE;
                    end
                end
            end
            MD_TRAVEL: begin
                if (cur == m_req && idle) begin
                    clr = m_req; m_mode = MD_DWELL; m_cnt = 0;
                end else if (m_dir) begin
                    up = pick_above(cur, m_req);
                    if (up != 0) m_req = up;
                end else begin
                    dn = pick_below(cur, m_req);
                    if (dn != 0) m_req = dn;
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt >= int'(DWELL)) m_mode = any ? MD_DISPATCH : MD_IDLE;
            end
        endcase
        for (int f = 1; f <= NF; f++) m_pend[f] = (m_pend[f] || rise[f]) && (f != clr);
        m_prev  = btn;
        m_armed = 1'b1;
    endtask

    task automatic plant_reset();
        car_pos = 0; car_idle_v = 1'b1; settle = 0; move_cnt = 0;
    endtask

    // Car moves one floor every two cycles toward the model's target while travelling.
    task automatic plant_step();
        if (m_mode == MD_TRAVEL && car_pos != m_req) begin
            car_idle_v = 1'b0;
            move_cnt++;
            if (move_cnt >= 2) begin
                move_cnt = 0;
                car_pos  = (m_req > car_pos) ? car_pos + 1 : car_pos - 1;
                if (car_pos == m_req) settle = rnd_mode ? int'($urandom_range(0, 2)) : 0;
            end
        end else if (settle > 0) begin
            settle--;
            car_idle_v = 1'b0;
        end else begin
            car_idle_v = 1'b1;
        end
    endtask

    task automatic tick(input bit [7:0] btn);
        call_buttons  = btn;
        current_floor = 4'(car_pos);
        car_idle      = car_idle_v;
        @(posedge clk);
        #1;
        model_step(btn, car_pos, car_idle_v);
        plant_step();
        sb_q.push_back(model_out());
    endtask

    task automatic apply_reset(input int cycles);
        bit popped;
        rst_n = 1'b1;
        #1;
        check("rst_requested_floor", int'(requested_floor), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_dir_up", int'(dir_up), 1);
        check("rst_busy", int'(busy), 0);
        model_reset();
        plant_reset();
        current_floor = 4'(car_pos);
        car_idle      = car_idle_v;
        popped = 1'b0;
        if (sb_q.size() > 0) begin
            void'(sb_q.pop_back());
            popped = 1'b1;
        end
        if (popped) sb_q.push_back(model_out());
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            sb_q.push_back(model_out());
        end
        rst_n = 1'b0;
    endtask

    // Monitor: compares every predicted cycle and logs requested_floor changes.
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = '{requested_floor, pending, dir_up, busy};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL sb_cycle: got req=%0d pend=%02h dir=%0d busy=%0d, expected req=%0d pend=%02h dir=%0d busy=%0d (t=%0t)",
                             a.req, a.pend, a.dir, a.bsy, e.req, e.pend, e.dir, e.bsy, $time);
                end
            end
            if (int'(requested_floor) != last_req) begin
                last_req = int'(requested_floor);
                if (log_en) req_log.push_back(last_req);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int       exp3 [3];
        bit [7:0] btn_r;
        exp3 = '{6, 7, 2};
        rnd_mode      = 1'b0;
        call_buttons  = '0;
        current_floor = '0;
        car_idle      = 1'b1;
        model_reset();
        plant_reset();
        apply_reset(3);
        tick(8'h00); tick(8'h00);

        // Single press from idle: latency and dwell.
        tick(8'h10);
        check("t2_pending_n1", int'(pending), 'h10);
        tick(8'h00);
        check("t2_req_n2", int'(requested_floor), 0);
        tick(8'h00);
        check("t2_req_n3", int'(requested_floor), 5);
        check("t2_busy_n3", int'(busy), 1);
        repeat (40) tick(8'h00);
        check("t2_pending_done", int'(pending), 0);
        check("t2_busy_done", int'(busy), 0);

        // Park the car at floor 3 heading up.
        tick(8'h01); repeat (40) tick(8'h00);
        tick(8'h04); repeat (30) tick(8'h00);
        check("t3_start_req", int'(requested_floor), 3);
        check("t3_start_dir", int'(dir_up), 1);

        // SCAN ordering of floors 2, 6, 7 from floor 3.
        req_log.delete();
        log_en = 1'b1;
        tick(8'h62);
        repeat (80) tick(8'h00);
        log_en = 1'b0;
        check("t3_seq_len", req_log.size(), 3);
        for (int i = 0; i < 3 && i < req_log.size(); i++) check("t3_seq", req_log[i], exp3[i]);
        check("t3_dir_after", int'(dir_up), 0);

        // Retarget ahead of the car, never behind it.
        tick(8'h01); repeat (30) tick(8'h00);
        tick(8'h40);
        for (int k = 0; k < 60 && !(car_pos == 3 && m_mode == MD_TRAVEL); k++) tick(8'h00);
        check("t4_reach_floor3", int'(car_pos == 3 && m_mode == MD_TRAVEL), 1);
        tick(8'h10);
        tick(8'h00);
        check("t4_retarget", int'(requested_floor), 5);
        tick(8'h02); tick(8'h00); tick(8'h00);
        check("t4_no_back_retarget", int'(requested_floor), 5);
        check("t4_floor2_pending", int'(pending[1]), 1);
        repeat (120) tick(8'h00);

        // Held button through arrival does not re-latch; a fresh press does.
        repeat (60) tick(8'h04);
        check("t5_held_cleared", int'(pending[2]), 0);
        repeat (3) tick(8'h00);
        tick(8'h04);
        check("t5_repress", int'(pending[2]), 1);
        repeat (20) tick(8'h00);

        // Async reset mid-travel with every button held.
        for (int k = 0; k < 60 && m_mode != MD_TRAVEL; k++) tick(8'hFF);
        check("t6_in_travel", int'(busy), 1);
        apply_reset(2);
        repeat (6) tick(8'hFF);
        check("t6_held_no_latch", int'(pending), 0);
        repeat (2) tick(8'h00);

        // Car position above the top floor.
        car_pos = 12;
        tick(8'h00); tick(8'h00);
        tick(8'h81);
        tick(8'h00); tick(8'h00);
        check("oob_req", int'(requested_floor), 8);
        check("oob_dir", int'(dir_up), 0);
        repeat (80) tick(8'h00);

        // Randomised traffic with occasional asynchronous resets.
        rnd_mode = 1'b1;
        btn_r    = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) btn_r[b] = ~btn_r[b];
            tick(btn_r);
            if ($urandom_range(0, 499) == 0) apply_reset(int'($urandom_range(1, 3)));
        end
        tick(8'h00);
        @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
Call-button front end for elevator_state_machine. Latches multi-hot call-button presses into a pending-request register. Orders the pending requests SCAN-style (continue in the current direction, then reverse). Drives requested_floor into the controller and retires each request once the car reports arrival, using current_floor and idle_display fed back from the controller.

Parameters:
NUM_FLOORS, 8, number of call buttons; button bit i requests floor i+1
FLOOR_W, 4, width of floor numbers
DWELL_CYCLES, 10, door-dwell cycles after arrival before the next dispatch (raise for real hardware)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-high reset (asserted when 1)
call_buttons  in  NUM_FLOORS  raw button levels, multi-hot allowed, synchronous to clk
current_floor  in  FLOOR_W  car position from elevator_state_machine
car_idle  in  1  controller idle_display (1 = not moving)
requested_floor  out  FLOOR_W  target floor to the controller, registered
pending  out  NUM_FLOORS  outstanding requests, bit i = floor i+1
dir_up  out  1  SCAN direction, 1 = up
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: requested_floor=0, pending=0, dir_up=1, busy=0, state=IDLE, dwell counter=0, button history=0. Reset is asynchronous, mid-operation included; the controller also returns to floor 0.
- Press capture:
  - Rising edge of call_buttons[i] (prev 0, now 1) sets pending[i] on the next clock.
  - A held button does not re-latch.
  - Several simultaneous edges all latch.
- States:
  - IDLE: pending != 0 -> DISPATCH.
  - DISPATCH, 1 cycle:
    - If pending holds current_floor: clear that bit and go to DWELL.
    - Otherwise pick the target. If dir_up, take the lowest pending floor > current_floor. If none, take the highest pending floor < current_floor and clear dir_up. The mirror rule applies when dir_up=0.
    - Register the target into requested_floor, then go to TRAVEL.
  - TRAVEL:
    - Arrival is current_floor == requested_floor && car_idle. On arrival, clear that pending bit and go to DWELL.
    - Retarget: if a pending floor lies strictly between current_floor and requested_floor in the travel direction, load the nearest such floor into requested_floor next cycle. Floors behind the car never retarget.
  - DWELL: count DWELL_CYCLES cycles, then go to DISPATCH if pending != 0, else IDLE. Presses are captured in every state.
- Latency: press edge at cycle n -> pending at n+1 -> DISPATCH at n+2 -> requested_floor valid at n+3 (from IDLE).
- requested_floor holds its last value while IDLE or DWELL, so the controller stays put.
- Simultaneous events:
  - A new press for the floor being retired in the same cycle is dropped, because the car is there.
  - A press for any other floor during a clear cycle latches normally.
- current_floor > NUM_FLOORS never matches a pending bit. Selection still works by magnitude compare.
- All floor compares are unsigned, FLOOR_W bits. The index-to-floor conversion is i+1, computed at FLOOR_W width.

Decomposition:
- elevator_pkg holds: FLOOR_W, NUM_FLOORS, the floor_t typedef, and the scheduler state enum (IDLE, DISPATCH, TRAVEL, DWELL).
- One combinational sub-module, scan_select. Inputs: pending, current_floor, dir_up. Outputs: found, target, new_dir, at_floor. It is shared by DISPATCH and the TRAVEL retarget check; the retarget check uses requested_floor as an upper/lower bound.

Test Plan:
1. rst_n=1 at any time -> requested_floor=0, pending=0x00, dir_up=1, busy=0 immediately. Release -> state IDLE.
2. current_floor=0, pulse bit 4 -> pending=0x10 at n+1, requested_floor=5 at n+3. Drive current_floor=5 with car_idle=1 -> pending=0x00, busy high for 4 DWELL cycles (DWELL_CYCLES=4), then busy=0.
3. Car at 3, dir_up=1, pending floors 2,6,7 (0x62) -> requested_floor sequence 6, 7, 2. dir_up falls when 2 is dispatched.
4. TRAVEL 1->7, current_floor=3, press floor 5 -> requested_floor=5 two cycles later. Press floor 2 -> requested_floor unchanged, pending[1] stays set.
5. Hold bit 2 (floor 3) high through arrival at floor 3 -> bit cleared and not re-latched. Release and re-press -> latches again.
6. Assert rst_n in TRAVEL with pending=0xFF -> all outputs return to reset values the same cycle. Buttons still held after release do not latch until they see a new rising edge.
